// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
//   Shared definitions for the multi-cycle RV32I-subset control path:
//   opcode constants, immediate-format select encodings, sequencer state
//   encodings and the one-hot instruction class produced by opcode_class_dec.
//   No ports (package).
// ----------------------------------------------------------------------------
package ctrl_pkg;

    // Major opcodes (instr[6:0]) of the supported instruction classes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Immediate generator format select
    localparam logic [1:0] IMM_I   = 2'b00;
    localparam logic [1:0] IMM_S   = 2'b01;
    localparam logic [1:0] IMM_B   = 2'b10;
    localparam logic [1:0] IMM_RSV = 2'b11;

    // Sequencer states; the numeric values are visible on the debug port
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXEC      = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5
    } state_t;

    // One-hot instruction class
    typedef struct packed {
        logic r;
        logic i;
        logic ld;
        logic st;
        logic br;
        logic illegal;
    } op_class_t;

    // Immediate format used by a class; R-type has no immediate and gets 00
    function automatic logic [1:0] imm_sel_for(input op_class_t cls);
        logic [1:0] sel;
        sel = IMM_I;
        if (cls.st) sel = IMM_S;
        if (cls.br) sel = IMM_B;
        return sel;
    endfunction

endpackage

// File: rtl/opcode_class_dec.sv
// ----------------------------------------------------------------------------
// opcode_class_dec
//   Purely combinational classifier: maps a 7-bit major opcode onto a one-hot
//   {r, i, ld, st, br, illegal} class vector. Anything outside the supported
//   subset is flagged illegal.
// Ports
//   op   in   7   major opcode
//   cls  out  6   one-hot class (op_class_t)
// ----------------------------------------------------------------------------
module opcode_class_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_R:      cls.r  = 1'b1;
            OP_I:      cls.i  = 1'b1;
            OP_LOAD:   cls.ld = 1'b1;
            OP_STORE:  cls.st = 1'b1;
            OP_BRANCH: cls.br = 1'b1;
            default:   cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle sequencer for the RV32I-subset datapath (R, I-ALU, load,
//   store, branch). Each instruction is split into FETCH / DECODE / EXEC /
//   MEM / WRITEBACK cycles; MEM stretches until the data RAM reports ready.
// Ports
//   clk      in   1        clock, rising edge
//   rst      in   1        asynchronous active-high reset (to IDLE)
//   OPCode   in   7        instr[6:0] from the instruction register
//   Zero     in   1        ALU zero flag, used in EXEC of a branch
//   ram_rdy  in   1        data RAM done, sampled only in MEM
//   PCEn     out  1        PC load enable
//   PCsrc    out  1        0: PC+4, 1: branch target
//   IREn     out  1        instruction register / old-PC load enable
//   EnW      out  1        register-file write enable
//   IMMSel   out  2        immediate format (00 I, 01 S, 10 B)
//   ALUsrc   out  1        0: rs2, 1: immediate
//   RAMW     out  1        data RAM write strobe
//   RAMR     out  1        data RAM read strobe
//   WB       out  1        writeback select, 1: RAM read data
//   illegal  out  1        pulse in DECODE for an unsupported opcode
//   retire   out  1        pulse in the last cycle of each legal instruction
//   state_o  out  STATE_W  current state (debug)
// ----------------------------------------------------------------------------
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         OPCode,
    input  logic               Zero,
    input  logic               ram_rdy,
    output logic               PCEn,
    output logic               PCsrc,
    output logic               IREn,
    output logic               EnW,
    output logic [1:0]         IMMSel,
    output logic               ALUsrc,
    output logic               RAMW,
    output logic               RAMR,
    output logic               WB,
    output logic               illegal,
    output logic               retire,
    output logic [STATE_W-1:0] state_o
);

    state_t     state;
    state_t     state_next;
    logic [6:0] op_q;
    logic [6:0] dec_op;
    op_class_t  cls;

    // During DECODE the opcode is not yet in op_q, so classify the live
    // input; afterwards the latched copy is authoritative even if the
    // instruction-register output moves.
    assign dec_op = (state == S_DECODE) ? OPCode : op_q;

    opcode_class_dec u_dec (
        .op  (dec_op),
        .cls (cls)
    );

    assign state_o = STATE_W'(state);

    // State register; reset abandons any in-flight instruction immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Opcode capture for the rest of the instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
        end else if (state == S_DECODE) begin
            op_q <= OPCode;
        end
    end

    // Next-state and control decode. Operand selects (ALUsrc/IMMSel) are
    // regenerated from op_q in MEM and WRITEBACK so they stay stable for
    // the whole instruction. Unused encodings fall back to IDLE.
    always_comb begin
        state_next = S_IDLE;
        PCEn       = 1'b0;
        PCsrc      = 1'b0;
        IREn       = 1'b0;
        EnW        = 1'b0;
        IMMSel     = IMM_I;
        ALUsrc     = 1'b0;
        RAMW       = 1'b0;
        RAMR       = 1'b0;
        WB         = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end

            S_FETCH: begin
                IREn       = 1'b1;
                PCEn       = 1'b1;
                state_next = S_DECODE;
            end

            S_DECODE: begin
                if (cls.illegal) begin
                    illegal    = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                ALUsrc = cls.i | cls.ld | cls.st;
                IMMSel = imm_sel_for(cls);
                if (cls.br) begin
                    // PC+imm is taken only when the comparison came out equal
                    PCsrc      = 1'b1;
                    PCEn       = Zero;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (cls.ld | cls.st) begin
                    state_next = S_MEM;
                end else if (cls.r | cls.i) begin
                    state_next = S_WRITEBACK;
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_MEM: begin
                ALUsrc = 1'b1;
                IMMSel = imm_sel_for(cls);
                RAMR   = cls.ld;
                RAMW   = cls.st;
                if (ram_rdy) begin
                    if (cls.ld) begin
                        state_next = S_WRITEBACK;
                    end else begin
                        retire     = cls.st;
                        state_next = S_FETCH;
                    end
                end else begin
                    state_next = S_MEM;
                end
            end

            S_WRITEBACK: begin
                ALUsrc     = cls.i | cls.ld;
                IMMSel     = imm_sel_for(cls);
                EnW        = 1'b1;
                retire     = 1'b1;
                WB         = cls.ld;
                state_next = S_FETCH;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
